// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, instruction layout, FSM states.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  localparam int INSTR_W  = 10;
  localparam int KIND_POS = 9;
  localparam int OP_LSB   = 6;
  localparam int RD_LSB   = 4;
  localparam int RS1_LSB  = 2;
  localparam int RS2_LSB  = 0;

  localparam logic KIND_ALU = 1'b0;
  localparam logic KIND_LDI = 1'b1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  typedef struct packed {
    logic       kind;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.kind = w[KIND_POS];
    d.op   = w[OP_LSB +: 3];
    d.rd   = w[RD_LSB +: 2];
    d.rs1  = w[RS1_LSB +: 2];
    d.rs2  = w[RS2_LSB +: 2];
    return d;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x WIDTH register file: one synchronous write port, two operand reads and a debug read.
module alu_regfile
  #(parameter int WIDTH = 4,
    parameter int NREGS = 4)
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [1:0]       waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [1:0]       ra1_i,
    input  logic [1:0]       ra2_i,
    input  logic [1:0]       dbg_addr_i,
    output logic [WIDTH-1:0] rd1_o,
    output logic [WIDTH-1:0] rd2_o,
    output logic [WIDTH-1:0] dbg_data_o
  );

  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we_i) regs_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  assign rd1_o      = regs_q[ra1_i];
  assign rd2_o      = regs_q[ra2_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Two-state sequencer: accepts an instruction, drives the external ALU for one cycle,
// then writes the ALU result (or immediate) back to the register file.
module alu_sequencer
  import alu_pkg::*;
  #(parameter int WIDTH = 4,
    parameter int NREGS = 4)
  (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [INSTR_W-1:0] in_instr_i,
    input  logic [WIDTH-1:0]   in_imm_i,
    output logic [WIDTH-1:0]   alu_a_o,
    output logic [WIDTH-1:0]   alu_b_o,
    output logic [2:0]         alu_op_o,
    input  logic [WIDTH-1:0]   alu_result_i,
    output logic               wb_valid_o,
    output logic [1:0]         wb_addr_o,
    output logic [WIDTH-1:0]   wb_data_o,
    output logic               zero_o,
    input  logic [1:0]         dbg_addr_i,
    output logic [WIDTH-1:0]   dbg_data_o
  );

  logic [0:0]         state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [WIDTH-1:0]   imm_q, imm_d;
  logic               wb_valid_q, wb_valid_d;
  logic [1:0]         wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0]   wb_data_q, wb_data_d;
  logic               zero_q, zero_d;

  instr_t           ins;
  logic             exec;
  logic [WIDTH-1:0] rs1_val, rs2_val, wdata;

  assign ins        = decode(instr_q);
  assign exec       = (state_q == ST_EXEC);
  assign in_ready_o = (state_q == ST_IDLE) && !rst;
  assign wdata      = (ins.kind == KIND_LDI) ? imm_q : alu_result_i;

  alu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk        (clk),
    .rst        (rst),
    .we_i       (exec),
    .waddr_i    (ins.rd),
    .wdata_i    (wdata),
    .ra1_i      (ins.rs1),
    .ra2_i      (ins.rs2),
    .dbg_addr_i (dbg_addr_i),
    .rd1_o      (rs1_val),
    .rd2_o      (rs2_val),
    .dbg_data_o (dbg_data_o)
  );

  // ALU sees operands only while executing an ALU-kind instruction; zero otherwise.
  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = ALU_ADD;
    if (exec && ins.kind == KIND_ALU) begin
      alu_a_o  = rs1_val;
      alu_b_o  = rs2_val;
      alu_op_o = ins.op;
    end
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    imm_d      = imm_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    zero_d     = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i && in_ready_o) begin
          instr_d = in_instr_i;
          imm_d   = in_imm_i;
          state_d = ST_EXEC;
        end
      end
      default: begin
        wb_valid_d = 1'b1;
        wb_addr_d  = ins.rd;
        wb_data_d  = wdata;
        zero_d     = (wdata == '0);
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      imm_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      zero_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      imm_q      <= imm_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      zero_q     <= zero_d;
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_addr_o  = wb_addr_q;
  assign wb_data_o  = wb_data_q;
  assign zero_o     = zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus random bench for alu_sequencer with a stub ALU and a register-array reference model.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 4;

  logic             clk, rst;
  logic             in_valid_i, in_ready_o;
  logic [9:0]       in_instr_i;
  logic [WIDTH-1:0] in_imm_i;
  logic [WIDTH-1:0] alu_a_o, alu_b_o, alu_result_i;
  logic [2:0]       alu_op_o;
  logic             wb_valid_o, zero_o;
  logic [1:0]       wb_addr_o, dbg_addr_i;
  logic [WIDTH-1:0] wb_data_o, dbg_data_o;

  int total = 0;
  int bad   = 0;

  int m_regs [4];
  int m_zero;

  alu_sequencer #(.WIDTH(WIDTH), .NREGS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_instr_i   (in_instr_i),
    .in_imm_i     (in_imm_i),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_op_o     (alu_op_o),
    .alu_result_i (alu_result_i),
    .wb_valid_o   (wb_valid_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o),
    .zero_o       (zero_o),
    .dbg_addr_i   (dbg_addr_i),
    .dbg_data_o   (dbg_data_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External combinational ALU, arithmetic on plain integers truncated to 4 bits.
  function automatic int alu_ref(input int op, input int a, input int b);
    int r;
    case (op)
      int'(ALU_ADD): r = a + b;
      int'(ALU_SUB): r = a - b;
      int'(ALU_AND): r = a & b;
      int'(ALU_OR):  r = a | b;
      int'(ALU_XOR): r = a ^ b;
      int'(ALU_SHL): r = a << b;
      int'(ALU_SHR): r = a >> b;
      default:       r = (a == b) ? 1 : 0;
    endcase
    return r & 15;
  endfunction

  always_comb alu_result_i = WIDTH'(alu_ref(int'(alu_op_o), int'(alu_a_o), int'(alu_b_o)));

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] mk(input int kind, input int op, input int rd,
                                    input int rs1, input int rs2);
    return {1'(kind), 3'(op), 2'(rd), 2'(rs1), 2'(rs2)};
  endfunction

  task automatic chk_all_regs(input string tag);
    for (int r = 0; r < 4; r++) begin
      dbg_addr_i = 2'(r);
      #1;
      chk(tag, int'(dbg_data_o), m_regs[r]);
    end
  endtask

  // Full handshake + execute + writeback of one instruction, checked against the model.
  task automatic issue(input logic [9:0] ins, input logic [3:0] imm);
    int n, kind, op, rd, rs1, rs2, ea, eb, eop, wd;
    n = 0;
    while (!in_ready_o && n < 20) begin tick(); n++; end
    if (n >= 20) chk("ready_timeout", int'(in_ready_o), 1);
    kind = int'(ins[9]); op = int'(ins[8:6]); rd = int'(ins[5:4]);
    rs1 = int'(ins[3:2]); rs2 = int'(ins[1:0]);
    in_valid_i = 1'b1; in_instr_i = ins; in_imm_i = imm;
    tick();
    in_valid_i = 1'b0;
    in_instr_i = 10'($urandom);
    in_imm_i   = 4'($urandom);
    #1;
    chk("exec_ready", int'(in_ready_o), 0);
    if (kind == 0) begin
      ea = m_regs[rs1]; eb = m_regs[rs2]; eop = op; wd = alu_ref(op, ea, eb);
    end else begin
      ea = 0; eb = 0; eop = 0; wd = int'(imm);
    end
    chk("alu_a", int'(alu_a_o), ea);
    chk("alu_b", int'(alu_b_o), eb);
    chk("alu_op", int'(alu_op_o), eop);
    tick();
    m_regs[rd] = wd;
    m_zero     = (wd == 0) ? 1 : 0;
    chk("wb_valid", int'(wb_valid_o), 1);
    chk("wb_addr", int'(wb_addr_o), rd);
    chk("wb_data", int'(wb_data_o), wd);
    chk("zero", int'(zero_o), m_zero);
    dbg_addr_i = 2'(rd);
    #1;
    chk("dbg_wb", int'(dbg_data_o), wd);
    tick();
    chk("wb_pulse_end", int'(wb_valid_o), 0);
  endtask

  initial begin
    logic [9:0] ldis [4];
    logic [3:0] imms [4];
    int idx, pulses, acc;

    rst = 1'b1; in_valid_i = 1'b0; in_instr_i = '0; in_imm_i = '0; dbg_addr_i = '0;
    for (int r = 0; r < 4; r++) m_regs[r] = 0;
    m_zero = 1;
    tick();
    in_valid_i = 1'b1;
    tick();
    chk("rst_ready_low", int'(in_ready_o), 0);
    in_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_ready", int'(in_ready_o), 1);
    chk("rst_zero", int'(zero_o), 1);
    chk("rst_wb_valid", int'(wb_valid_o), 0);
    chk("rst_wb_data", int'(wb_data_o), 0);
    chk("rst_alu_a", int'(alu_a_o), 0);
    chk("rst_alu_op", int'(alu_op_o), 0);
    chk_all_regs("rst_regs");
    tick();
    chk("idle_wb_valid", int'(wb_valid_o), 0);

    // Directed: LDI r1=5, LDI r2=3, ADD r0=r1+r2, SUB r3=r1-r1, XOR r1=r1^r2, ADD r0=r1+r1
    issue(mk(1, 0, 1, 0, 0), 4'd5);
    issue(mk(1, 0, 2, 0, 0), 4'd3);
    issue(mk(0, 0, 0, 1, 2), 4'd0);
    chk("add_r0", m_regs[0], 8);
    issue(mk(0, 1, 3, 1, 1), 4'd9);
    chk("sub_zero", int'(zero_o), 1);
    issue(mk(0, 4, 1, 1, 2), 4'd0);
    chk("xor_r1", m_regs[1], 6);
    issue(mk(0, 0, 0, 1, 1), 4'd0);
    chk_all_regs("directed_regs");

    // Back-to-back: valid held high across 4 LDIs.
    imms[0] = 4'd7; imms[1] = 4'd0; imms[2] = 4'd12; imms[3] = 4'd1;
    for (int k = 0; k < 4; k++) ldis[k] = mk(1, 7, k, 3, 3);
    idx = 0; pulses = 0;
    in_valid_i = 1'b1; in_instr_i = ldis[0]; in_imm_i = imms[0];
    for (int c = 0; c < 8; c++) begin
      chk("b2b_ready", int'(in_ready_o), (c % 2 == 0) ? 1 : 0);
      acc = (in_ready_o && in_valid_i) ? 1 : 0;
      tick();
      if (wb_valid_o) pulses++;
      if (acc != 0) begin
        m_regs[idx] = int'(imms[idx]);
        idx++;
        if (idx < 4) begin in_instr_i = ldis[idx]; in_imm_i = imms[idx]; end
        else in_valid_i = 1'b0;
      end
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (wb_valid_o) pulses++;
    end
    chk("b2b_pulses", pulses, 4);
    chk("b2b_zero", int'(zero_o), 0);
    m_zero = 0;
    chk_all_regs("b2b_regs");

    // Random instructions against the model.
    for (int i = 0; i < 40; i++) issue(10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)));
    chk_all_regs("rand_regs");

    // Reset in the middle of EXEC of ADD r0 with r0=8.
    issue(mk(1, 0, 0, 0, 0), 4'd8);
    in_valid_i = 1'b1; in_instr_i = mk(0, 0, 0, 0, 0); in_imm_i = '0;
    tick();
    in_valid_i = 1'b0;
    chk("mid_exec_ready", int'(in_ready_o), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", int'(in_ready_o), 0);
    tick();
    chk("mid_rst_wb", int'(wb_valid_o), 0);
    rst = 1'b0;
    #1;
    for (int r = 0; r < 4; r++) m_regs[r] = 0;
    chk("post_rst_ready", int'(in_ready_o), 1);
    chk("post_rst_zero", int'(zero_o), 1);
    chk_all_regs("post_rst_regs");
    tick();
    chk("post_rst_wb", int'(wb_valid_o), 0);
    issue(mk(1, 0, 2, 0, 0), 4'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator side of the 4-bit ALU interface. It accepts instructions over a valid/ready handshake and holds a 4-entry register file.
- It drives operands and an opcode to an external combinational ALU, then writes the ALU result back into the register file.
- Sits between the instruction source (test harness or future fetch unit) and the ALU. This is the first stateful datapath element in the design.

Parameters:
- WIDTH, 4, data width of register-file entries, ALU operands/result and the immediate.
- NREGS, 4, number of register-file entries. Fixed at 4 by the 2-bit register fields.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid_i  input  1  instruction present.
- in_ready_o  output  1  sequencer can accept an instruction.
- in_instr_i  input  10  instruction word:
  - [9] kind: 0 = ALU op, 1 = load-immediate.
  - [8:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2.
- in_imm_i  input  WIDTH  immediate data, used only when kind=1.
- alu_a_o  output  WIDTH  ALU operand a.
- alu_b_o  output  WIDTH  ALU operand b.
- alu_op_o  output  3  ALU opcode. Encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 eq.
- alu_result_i  input  WIDTH  combinational result from the ALU.
- wb_valid_o  output  1  one-cycle pulse: a register write completed.
- wb_addr_o  output  2  register written.
- wb_data_o  output  WIDTH  value written.
- zero_o  output  1  sticky flag: last written value was 0.
- dbg_addr_i  input  2  debug read address.
- dbg_data_o  output  WIDTH  combinational read of regs[dbg_addr_i].

Behaviour:
- Reset: synchronous on rst=1 at a rising edge.
  - All regs := 0, state := IDLE, instruction latch := 0.
  - wb_valid_o=0, wb_addr_o=0, wb_data_o=0, zero_o=1.
  - alu_a_o/alu_b_o/alu_op_o = 0.
  - in_ready_o is 0 while rst is high.
- States: IDLE, EXEC.
  - IDLE: in_ready_o=1. On in_valid_i & in_ready_o at edge E0: latch in_instr_i and in_imm_i, go to EXEC.
  - EXEC: exactly one cycle; in_ready_o=0.
    - kind=0: alu_a_o=regs[rs1], alu_b_o=regs[rs2], alu_op_o=op. All combinational from the latched instruction and the current regs.
    - kind=1: ALU outputs remain 0; op/rs fields are ignored.
    - At edge E1: wdata := alu_result_i (kind=0) or latched imm (kind=1); regs[rd] := wdata; wb_addr_o := rd; wb_data_o := wdata; wb_valid_o := 1; zero_o := (wdata==0). State returns to IDLE.
- wb_valid_o is high for exactly the cycle after E1 and is 0 otherwise.
- In IDLE and after reset, the ALU outputs are forced to 0.
- Latency: handshake to register update is 2 edges. Throughput is 1 instruction per 2 cycles; in_ready_o toggles 1,0,1,0 under back-to-back valid.
- Hazards: rd==rs1 or rd==rs2 reads the old value (write happens at end of EXEC). Back-to-back dependent instructions see the updated value, because the next EXEC is ≥2 cycles later.
- in_valid_i while in_ready_o=0: ignored. The source must hold the instruction; nothing is latched.
- Arithmetic: the result is taken as WIDTH bits from the ALU. Overflow and shift-out bits are the ALU's concern; the eq op returns 0 or 1.
- Reset mid-EXEC: the instruction is dropped, no writeback, and no wb_valid_o pulse.
- dbg_data_o reflects a write from the cycle after the edge.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams: ALU_ADD..ALU_EQ, matching the ALU encoding.
  - instruction field positions.
  - KIND_ALU / KIND_LDI constants.
  - state encoding.
- Sub-module alu_regfile: 4xWIDTH register file with one sync write port, two combinational operand read ports and one combinational debug read port; reset clears all entries.
- Sequencer FSM stays in alu_sequencer.

Test Plan:
- Reset then idle: after reset, dbg reads 0 for all 4 regs; zero_o=1; in_ready_o=1; wb_valid_o=0.
- LDI r1=5, LDI r2=3, ADD r0=r1+r2 (instr 0_000_00_01_10):
  - EXEC cycle shows alu_a_o=5, alu_b_o=3, alu_op_o=000.
  - Stub ALU returns 8; wb pulse addr=0, data=8; zero_o=0; dbg r0=8.
- SUB r3=r1-r1 with r1=5: ALU returns 0 → wb data=0, zero_o=1.
- In-place: r1=5, XOR r1=r1^r2 with r2=3:
  - operands in EXEC are 5 and 3; r1 becomes 6.
  - A following ADD r0=r1+r1 sees a=6, b=6.
- Back-to-back valid held high for 4 LDIs: in_ready_o pattern 1,0,1,0,…; exactly 4 wb pulses, each one cycle wide; the held instruction is never double-accepted.
- Assert rst during EXEC of ADD r0 (r0 was 8): no wb pulse; all regs read 0 afterwards; state IDLE; in_ready_o=1 on the first cycle after rst deasserts.
